// File: rtl/piso_tx_sched.sv
// Round-robin scheduler sharing one PISO shift register among N_REQ requesters.
// Grants one word at a time, loads it into the PISO, frames WIDTH serial bits
// (MSB first), then inserts GAP idle cycles before the next grant.
//
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   req, req_data   per-requester level request and packed words
//   ack             one-hot grant pulse, word captured that cycle
//   sr_en, sr_d     PISO control (0 = load sr_d) and parallel data
//   sdo_valid/first/last  framing of the PISO MSB bit
//   cur_id, busy    owner of current word, SHIFT/GAP indicator
module piso_tx_sched #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 4,
   parameter int GAP   = 0,
   localparam int IDW = $clog2(N_REQ),
   localparam int BW  = $clog2(WIDTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       ack,
   output logic                   sr_en,
   output logic [WIDTH-1:0]       sr_d,
   output logic                   sdo_valid,
   output logic                   sdo_first,
   output logic                   sdo_last,
   output logic [IDW-1:0]         cur_id,
   output logic                   busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   // Only meaningful when GAP > 0; the GAP state is unreachable otherwise.
   localparam logic [3:0] GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

   state_t         state_q;
   logic [BW-1:0]  bit_q;
   logic [3:0]     gap_q;
   logic [IDW-1:0] last_q;
   logic [IDW-1:0] cur_q;

   logic           is_idle;
   logic           is_shift;
   logic           is_gap;
   logic           slot;
   logic           grant;
   logic [IDW-1:0] win_d;

   assign is_idle  = (state_q == S_IDLE);
   assign is_shift = (state_q == S_SHIFT);
   assign is_gap   = (state_q == S_GAP);

   // Arbitration slot: idle, last shift bit (no gap), or last gap cycle.
   assign slot = is_idle
               | (is_shift & (bit_q == BIT_LAST) & (GAP == 0))
               | (is_gap & (gap_q == GAP_LAST));

   // Reset wins over a grant in the same cycle.
   assign grant = reset & slot & (|req);

   // Rotating priority: first request above last_q, wrapping.
   always_comb begin
      logic found;
      found = 1'b0;
      win_d = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         int idx;
         idx = (int'(last_q) + k) % N_REQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            win_d = IDW'(idx);
         end
      end
   end

   always_comb begin
      ack = '0;
      if (grant) ack[win_d] = 1'b1;
   end

   assign sr_en = ~grant;
   assign sr_d  = grant ? req_data[win_d*WIDTH +: WIDTH]
                        : '0;

   assign sdo_valid = is_shift;
   assign sdo_first = is_shift & (bit_q == '0);
   assign sdo_last  = is_shift & (bit_q == BIT_LAST);
   assign busy      = ~is_idle;
   assign cur_id    = cur_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         bit_q   <= '0;
         gap_q   <= '0;
         last_q  <= IDW'(N_REQ - 1);
         cur_q   <= '0;
      end else if (grant) begin
         state_q <= S_SHIFT;
         bit_q   <= '0;
         last_q  <= win_d;
         cur_q   <= win_d;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_q <= S_IDLE;
            end
            S_SHIFT: begin
               if (bit_q == BIT_LAST) begin
                  if (GAP > 0) begin
                     state_q <= S_GAP;
                     gap_q   <= '0;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else begin
                  bit_q <= bit_q + 1'b1;
               end
            end
            S_GAP: begin
               if (gap_q == GAP_LAST) begin
                  state_q <= S_IDLE;
               end else begin
                  gap_q <= gap_q + 4'd1;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piso_tx_sched.sv
// Bench for piso_tx_sched: two instances (GAP=0, GAP=2) checked each cycle
// against a grant-time based reference model plus a bench PISO register.
module tb_piso_tx_sched;

   localparam int N  = 4;
   localparam int W  = 4;
   localparam int G0 = 0;
   localparam int G1 = 2;

   logic clk;
   logic rst_v;

   logic [N-1:0]   req_v  [2];
   logic [N*W-1:0] data_v [2];
   logic [N-1:0]   ack_w  [2];
   logic           en_w   [2];
   logic [W-1:0]   d_w    [2];
   logic           vld_w  [2];
   logic           fst_w  [2];
   logic           lst_w  [2];
   logic [1:0]     cid_w  [2];
   logic           bsy_w  [2];

   int n_tests;
   int n_fail;
   int cyc;

   // Reference model: time of last grant, word, rotating pointer.
   bit           m_act  [2];
   int           m_tg   [2];
   int           m_last [2];
   int           m_cur  [2];
   logic [W-1:0] m_word [2];
   logic [W-1:0] piso   [2];
   logic [N-1:0] last_ack [2];

   piso_tx_sched #(.N_REQ(N), .WIDTH(W), .GAP(G0)) u_dut0 (
      .clk(clk), .reset(rst_v),
      .req(req_v[0]), .req_data(data_v[0]),
      .ack(ack_w[0]), .sr_en(en_w[0]), .sr_d(d_w[0]),
      .sdo_valid(vld_w[0]), .sdo_first(fst_w[0]),
      .sdo_last(lst_w[0]), .cur_id(cid_w[0]), .busy(bsy_w[0])
   );

   piso_tx_sched #(.N_REQ(N), .WIDTH(W), .GAP(G1)) u_dut1 (
      .clk(clk), .reset(rst_v),
      .req(req_v[1]), .req_data(data_v[1]),
      .ack(ack_w[1]), .sr_en(en_w[1]), .sr_d(d_w[1]),
      .sdo_valid(vld_w[1]), .sdo_first(fst_w[1]),
      .sdo_last(lst_w[1]), .cur_id(cid_w[1]), .busy(bsy_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic string tg(input int m, input string s);
      return $sformatf("u%0d.%s@%0d", m, s, cyc);
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         int gap;
         int off;
         int win;
         bit inw;
         bit slot;
         bit g;
         bit e_vld;
         logic [N-1:0] e_ack;
         logic [W-1:0] e_d;
         gap  = (m == 0) ? G0 : G1;
         off  = cyc - m_tg[m];
         inw  = m_act[m] && off >= 1 && off <= W + gap;
         slot = !inw || off == W + gap;
         g    = rst_v && slot && (req_v[m] != '0);
         win  = 0;
         for (int k = N; k >= 1; k--) begin
            int idx;
            idx = (m_last[m] + k) % N;
            if (req_v[m][idx]) win = idx;
         end
         e_ack = '0;
         e_d   = '0;
         if (g) begin
            e_ack[win] = 1'b1;
            e_d = data_v[m][win*W +: W];
         end
         e_vld = inw && off <= W;
         chk(tg(m, "ack"), 32'(ack_w[m]), 32'(e_ack));
         chk(tg(m, "onehot"), 32'($countones(ack_w[m]) <= 1), 1);
         chk(tg(m, "sr_en"), 32'(en_w[m]), 32'(!g));
         chk(tg(m, "sr_d"), 32'(d_w[m]), 32'(e_d));
         chk(tg(m, "valid"), 32'(vld_w[m]), 32'(e_vld));
         chk(tg(m, "first"), 32'(fst_w[m]), 32'(e_vld && off == 1));
         chk(tg(m, "last"), 32'(lst_w[m]), 32'(e_vld && off == W));
         chk(tg(m, "busy"), 32'(bsy_w[m]), 32'(inw));
         chk(tg(m, "cur_id"), 32'(cid_w[m]), 32'(m_cur[m]));
         if (e_vld)
            chk(tg(m, "sdo"), 32'(piso[m][W-1]), 32'(m_word[m][W-off]));
         if (!rst_v) piso[m] = '0;
         else if (!en_w[m]) piso[m] = d_w[m];
         else piso[m] = piso[m] << 1;
         if (!rst_v) begin
            m_act[m]  = 1'b0;
            m_last[m] = N - 1;
            m_cur[m]  = 0;
         end else if (g) begin
            m_act[m]  = 1'b1;
            m_tg[m]   = cyc;
            m_last[m] = win;
            m_cur[m]  = win;
            m_word[m] = e_d;
         end
         last_ack[m] = e_ack;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_ack(input int m, input logic [N-1:0] mask);
      for (int i = 0; i < 50; i++) begin
         step();
         if ((last_ack[m] & mask) != '0) break;
      end
      chk(tg(m, "ack_wait"), 32'((last_ack[m] & mask) != '0), 1);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      rst_v   = 1'b0;
      for (int m = 0; m < 2; m++) begin
         req_v[m]    = '0;
         data_v[m]   = '0;
         m_act[m]    = 1'b0;
         m_tg[m]     = 0;
         m_last[m]   = N - 1;
         m_cur[m]    = 0;
         m_word[m]   = '0;
         piso[m]     = '0;
         last_ack[m] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst_v = 1'b1;

      // Single word from requester 2.
      req_v[0] = 4'b0100;
      data_v[0][11:8] = 4'b1011;
      step();
      chk("single_ack", 32'(last_ack[0]), 32'(4'b0100));
      req_v[0] = '0;
      run(6);

      // Full contention (GAP=0) and gap insertion (GAP=2).
      data_v[0] = 16'hC5A3;
      data_v[1] = 16'h0006;
      req_v[0]  = 4'b1111;
      req_v[1]  = 4'b0001;
      run(20);
      req_v[0] = '0;
      req_v[1] = '0;
      run(8);

      // Round-robin after a grant to requester 3.
      data_v[0] = 16'h9E71;
      req_v[0] = 4'b1000;
      wait_ack(0, 4'b1000);
      req_v[0] = 4'b1001;
      wait_ack(0, 4'b1001);
      chk("rr_next", 32'(last_ack[0]), 32'(4'b0001));
      req_v[0] = 4'b1000;
      wait_ack(0, 4'b1000);
      chk("rr_back", 32'(last_ack[0]), 32'(4'b1000));
      req_v[0] = '0;
      run(6);

      // Withdrawn request during a word.
      req_v[0] = 4'b0001;
      wait_ack(0, 4'b0001);
      req_v[0] = 4'b0010;
      run(2);
      req_v[0] = '0;
      run(6);

      // Reset in the middle of a word.
      req_v[0] = 4'b0001;
      req_v[1] = 4'b0001;
      wait_ack(0, 4'b0001);
      req_v[0] = '0;
      req_v[1] = '0;
      step();
      rst_v = 1'b0;
      step();
      req_v[0] = 4'b1010;
      req_v[1] = 4'b1010;
      step();
      rst_v = 1'b1;
      wait_ack(0, 4'b1010);
      chk("rst_first", 32'(last_ack[0]), 32'(4'b0010));
      req_v[0] = '0;
      req_v[1] = '0;
      run(10);

      // Randomized traffic with occasional withdrawal and reset.
      for (int c = 0; c < 800; c++) begin
         for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < N; i++) begin
               if (!req_v[m][i] && $urandom_range(0, 3) == 0) begin
                  req_v[m][i] = 1'b1;
                  data_v[m][i*W +: W] = W'($urandom);
               end else if ($urandom_range(0, 60) == 0) begin
                  req_v[m][i] = 1'b0;
               end
            end
         end
         rst_v = ($urandom_range(0, 99) != 0);
         step();
         req_v[0] = req_v[0] & ~last_ack[0];
         req_v[1] = req_v[1] & ~last_ack[1];
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
